// File: rtl/adc128s022_scan_ctrl.sv
// ============================================================================
// Module   : adc128s022_scan_ctrl
// Purpose  : Multi-channel scan controller for the ADC128S022 serial ADC.
//            Optional continuous scanning: ADC128S022_SCAN_CONT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc128s022_scan_ctrl #(
    parameter int SCLK_HALF = 10,
    parameter int N_CH      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  CH_MASK,
    input  logic        CONT,
    output logic        BUSY,
    output logic [11:0] DATA,
    output logic [2:0]  DATA_CH,
    output logic        DATA_VALID,
    output logic        DONE,
    output logic        adc_sclk,
    output logic        adc_saddr,
    output logic        adc_csn,
    input  logic        adc_sdat
);

    localparam logic [7:0] CH_LIMIT  = 8'((1 << N_CH) - 1);
    localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_CS_HOLD  = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic [7:0]  hcnt_q,    hcnt_d;
    logic        phase_q,   phase_d;
    logic [3:0]  bit_q,     bit_d;
    logic [7:0]  mask_q,    mask_d;
    logic [2:0]  cur_ch_q,  cur_ch_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic        last_q,    last_d;
    logic        first_q,   first_d;
    logic [10:0] shift_q,   shift_d;
    logic        busy_q,    busy_d;
    logic [11:0] data_q,    data_d;
    logic [2:0]  data_ch_q, data_ch_d;
    logic        valid_q,   valid_d;
    logic        done_q,    done_d;
    logic        sclk_q,    sclk_d;
    logic        saddr_q,   saddr_d;
    logic        csn_q,     csn_d;

    logic [7:0]  w_mask_eff;
    logic [3:0]  w_first_sel;
    logic [3:0]  w_next_sel;
    logic        w_wrap_en;

`ifdef ADC128S022_SCAN_CONT_EN
    assign w_wrap_en = CONT;
`else
    logic cont_unused;
    assign cont_unused = CONT;
    assign w_wrap_en   = 1'b0;
`endif

    // Returns {wrapped, channel}: lowest enabled channel above cur, or the
    // lowest enabled channel overall (wrapped=1) when none lies above.
    function automatic logic [3:0] next_enabled(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] lowest;
        logic [2:0] above;
        logic       found;
        lowest = '0;
        above  = '0;
        found  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                lowest = 3'(i);
                if (i > int'(cur)) begin
                    above = 3'(i);
                    found = 1'b1;
                end
            end
        end
        return found ? {1'b0, above} : {1'b1, lowest};
    endfunction

    // Address bits A2..A0 go out on SCLK clocks 3..5 (bit indices 2..4).
    function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] ch);
        case (b)
            4'd2:    return ch[2];
            4'd3:    return ch[1];
            4'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    assign w_mask_eff  = CH_MASK & CH_LIMIT;
    assign w_first_sel = next_enabled(w_mask_eff, 3'd7);
    assign w_next_sel  = next_enabled(mask_q, cur_ch_q);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        mask_d    = mask_q;
        cur_ch_d  = cur_ch_q;
        prev_ch_d = prev_ch_q;
        last_d    = last_q;
        first_d   = first_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        saddr_d   = saddr_q;
        csn_d     = csn_q;

        case (state_q)
            ST_IDLE: begin
                if (START && (w_mask_eff != 8'd0)) begin
                    state_d  = ST_CS_SETUP;
                    mask_d   = w_mask_eff;
                    cur_ch_d = w_first_sel[2:0];
                    hcnt_d   = '0;
                    csn_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            ST_CS_SETUP: begin
                if (hcnt_q == HALF_LAST) begin
                    state_d = ST_SHIFT;
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    saddr_d = 1'b0;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            ST_SHIFT: begin
                if (hcnt_q != HALF_LAST) begin
                    hcnt_d = hcnt_q + 8'd1;
                end else begin
                    hcnt_d = '0;
                    if (!phase_q) begin
                        // SCLK rising edge: sample DOUT
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                        shift_d = {shift_q[9:0], adc_sdat};
                        if (bit_q == 4'd15 && !first_q) begin
                            data_d    = {shift_q, adc_sdat};
                            data_ch_d = prev_ch_q;
                            valid_d   = 1'b1;
                        end
                    end else if (bit_q != 4'd15) begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        bit_d   = bit_q + 4'd1;
                        saddr_d = addr_bit(bit_q + 4'd1, cur_ch_q);
                    end else begin
                        bit_d = '0;
                        if (last_q && !w_wrap_en) begin
                            state_d = ST_CS_HOLD;
                            saddr_d = 1'b0;
                        end else begin
                            // Next frame starts immediately; csn stays low.
                            sclk_d    = 1'b0;
                            phase_d   = 1'b0;
                            saddr_d   = 1'b0;
                            first_d   = 1'b0;
                            prev_ch_d = cur_ch_q;
                            cur_ch_d  = w_next_sel[2:0];
                            last_d    = w_next_sel[3];
                            done_d    = last_q;
                        end
                    end
                end
            end

            ST_CS_HOLD: begin
                if (hcnt_q == HALF_LAST) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                    csn_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            mask_q    <= '0;
            cur_ch_q  <= '0;
            prev_ch_q <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            data_ch_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b1;
            saddr_q   <= 1'b0;
            csn_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            mask_q    <= mask_d;
            cur_ch_q  <= cur_ch_d;
            prev_ch_q <= prev_ch_d;
            last_q    <= last_d;
            first_q   <= first_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            saddr_q   <= saddr_d;
            csn_q     <= csn_d;
        end
    end

    assign BUSY       = busy_q;
    assign DATA       = data_q;
    assign DATA_CH    = data_ch_q;
    assign DATA_VALID = valid_q;
    assign DONE       = done_q;
    assign adc_sclk   = sclk_q;
    assign adc_saddr  = saddr_q;
    assign adc_csn    = csn_q;

endmodule

`default_nettype wire
